// File: rtl/m_ext_pkg.sv
// Shared encodings for the RV32M sequencer: funct3 ops, FSM states, step count.
package m_ext_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int XLEN_STEPS = 32;

endpackage

// File: rtl/m_ext_iter_datapath.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes,
// with sign fix-up and the divide-by-zero / overflow short-cut results.
module m_ext_iter_datapath
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            skip,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m;
    funct3_e           op;
    logic              neg_q, neg_r, sp;
    logic [XLEN-1:0]   sp_res;

    logic              sa_en, sb_en, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div0, ovf;

    always_comb begin
        sa_en  = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
        sb_en  = funct3[2] ? ~funct3[0] : ~funct3[1];
        sign_a = sa_en & srcA[XLEN-1];
        sign_b = sb_en & srcB[XLEN-1];
        mag_a  = sign_a ? -srcA : srcA;
        mag_b  = sign_b ? -srcB : srcB;
        div0   = funct3[2] & (srcB == '0);
        ovf    = funct3[2] & ~funct3[0] & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (srcB == '1);
        skip   = div0 | ovf;
    end

    // Multiply accumulates into the high half while the multiplier shifts out
    // the low half; divide shifts {remainder, quotient} left one bit per step.
    logic [XLEN:0]   msum;
    logic [XLEN+1:0] dtrial;

    always_comb begin
        msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        dtrial = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, m};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            m      <= '0;
            op     <= F3_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            sp     <= 1'b0;
            sp_res <= '0;
        end else if (load) begin
            op     <= funct3_e'(funct3);
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            sp     <= skip;
            m      <= funct3[2] ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            if (div0)
                sp_res <= funct3[1] ? srcA : '1;
            else
                sp_res <= funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else if (step) begin
            if (!op[2])
                acc <= {msum, acc[XLEN-1:1]};
            else if (!dtrial[XLEN+1])
                acc <= {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc <= {acc[2*XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        result = '0;
        if (sp)
            result = sp_res;
        else if (!op[2])
            result = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            result = op[1] ? rem : quo;
    end

endmodule

// File: rtl/m_ext_sequencer.sv
// RV32M sequencer: stalls the core for a 32-step multiply/divide and pulses
// aluResultSrc for one cycle when the result is ready.
module m_ext_sequencer
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mStart,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            stall,
    output logic            aluResultSrc,
    output logic [XLEN-1:0] multResult,
    output logic            busy
);

    logic [1:0]      state;
    logic [4:0]      cnt;
    logic            load, skip;
    logic [XLEN-1:0] dp_result;

    assign load         = (state == S_IDLE) & mStart;
    assign busy         = (state == S_MUL) | (state == S_DIV);
    assign aluResultSrc = (state == S_DONE);
    assign stall        = ~reset & (load | busy);
    assign multResult   = aluResultSrc ? dp_result : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (mStart) begin
                    cnt <= '0;
                    if (!funct3[2])
                        state <= S_MUL;
                    else
                        state <= skip ? S_DONE : S_DIV;
                end
                S_MUL, S_DIV: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(XLEN_STEPS - 1))
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    m_ext_iter_datapath #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (busy),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .skip   (skip),
        .result (dp_result)
    );

endmodule
